// File: rtl/tau_pkg.sv
// tau_pkg: shared width derivations and constants for the multi-tau correlator stages.
package tau_pkg;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int tau_bw(input int maxbin);
    return clog2(maxbin) + 1;
  endfunction
  function automatic int tau_ow(input int dw, input int maxbin);
    return dw + clog2(maxbin);
  endfunction
  function automatic longint TAU_SAT_MAX(input int dw);
    return (longint'(1) << dw) - 1;
  endfunction
endpackage

// File: rtl/tau_acc_lane.sv
// tau_acc_lane: one channel accumulator with optional saturation back to input width.
module tau_acc_lane import tau_pkg::*; #(
  parameter int DW = 8,
  parameter int OW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          add,
  input  logic          done,
  input  logic          sat_mode,
  input  logic [DW-1:0] din,
  output logic [OW-1:0] dout,
  output logic          clip
);
  localparam logic [OW-1:0] SMAX = OW'(TAU_SAT_MAX(DW));
  logic [OW-1:0] acc, sum;
  logic over;
  assign sum = acc + OW'(din);
  assign over = sum > SMAX;
  // done is pre-gated by the top with sin and !clr, so a completing sample restarts the bin
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc  <= '0;
      dout <= '0;
      clip <= 1'b0;
    end else begin
      acc  <= (clr || done) ? '0 : add ? sum : acc;
      dout <= !done ? '0 : (sat_mode && over) ? SMAX : sum;
      clip <= done && sat_mode && over;
    end
endmodule

// File: rtl/tau_bin_accum.sv
// tau_bin_accum: sums bin_m strobed samples per channel and emits one result per bin.
module tau_bin_accum import tau_pkg::*; #(
  parameter int DW = 8,
  parameter int CH = 2,
  parameter int MAXBIN = 16,
  localparam int BW = tau_bw(MAXBIN),
  localparam int OW = tau_ow(DW, MAXBIN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [BW-1:0]    bin_m,
  input  logic             sat_mode,
  input  logic [CH*DW-1:0] din,
  input  logic             sin,
  output logic [CH*OW-1:0] dout,
  output logic             sout,
  output logic             sat
);
  logic [BW-1:0] cnt, fac, fac_in, fac_eff;
  logic [CH-1:0] clip;
  logic add, done;
  assign fac_in = (bin_m == '0) ? BW'(1) : (bin_m > BW'(MAXBIN)) ? BW'(MAXBIN) : bin_m;
  // the first sample of a bin uses the fresh factor; later samples use the latched one
  assign fac_eff = (cnt == '0) ? fac_in : fac;
  assign add = sin && !clr;
  assign done = add && (cnt + BW'(1) == fac_eff);
  assign sat = |clip;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      fac  <= BW'(1);
      sout <= 1'b0;
    end else begin
      cnt  <= (clr || done) ? '0 : add ? cnt + BW'(1) : cnt;
      fac  <= (add && cnt == '0) ? fac_in : fac;
      sout <= done;
    end
  for (genvar c = 0; c < CH; c++) begin : g_lane
    tau_acc_lane #(.DW(DW), .OW(OW)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .add      (add),
      .done     (done),
      .sat_mode (sat_mode),
      .din      (din[c*DW +: DW]),
      .dout     (dout[c*OW +: OW]),
      .clip     (clip[c])
    );
  end
endmodule

// File: doc/tau_bin_accum.md
# tau_bin_accum

Parametrised multi-channel binning stage for the RAM-based multi-tau correlator. It sums exactly `bin_m` consecutive strobed samples per channel and emits one result per completed bin. The result is either full width or saturated back to input width, so stages can be cascaded to build successive tau levels. Sits between a lag-level output and the next coarser lag level.

## Interface
- `DW`, 8: input sample width per channel.
- `CH`, 2: number of channels; all channels share one strobe.
- `MAXBIN`, 16: largest supported binning factor; must be ≥ 2.
- `BW`, derived = clog2(MAXBIN)+1: width of `bin_m` and of the internal counter.
- `OW`, derived = DW + clog2(MAXBIN): full-width sum per channel.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clr` input 1: synchronous flush of the partial bin.
- `bin_m` input BW: binning factor, unsigned.
- `sat_mode` input 1: 0 = full-width output; 1 = saturate to DW (upper OW-DW bits zero).
- `din` input CH*DW: channel c at bits [c*DW +: DW], unsigned.
- `sin` input 1: sample strobe.
- `dout` output CH*OW: channel c at bits [c*OW +: OW].
- `sout` output 1: one-cycle result strobe.
- `sat` output 1: at least one channel clipped in this result; valid with `sout`.

## Operation
- Reset values: `sout`=0, `dout`=0, `sat`=0, counter=0, all accumulators=0, latched factor=1.
- **Factor latch:** `bin_m` is latched only on the `sin` that starts a bin (counter==0).
  - 0 is treated as 1; values > MAXBIN are clamped to MAXBIN.
  - Changes to `bin_m` mid-bin have no effect until the next bin.
- **Accumulation:** each `sin` adds `din[c]` to `acc[c]`, zero-extended to OW, and increments the counter.
  - No overflow is possible: MAXBIN·(2^DW−1) < 2^OW.
- **Completion:** on the `sin` that makes counter == latched factor:
  - The final sum includes that cycle's `din`.
  - The result registers load.
  - Counter and accumulators return to 0 in the same edge.
  - There is no dead cycle: a `sin` on the very next cycle starts a new bin.
- **Counter:** counts 0 … factor−1 as the wrap boundary; no sample is ever dropped.
- **sin low:** counter and accumulators hold.
- **clr:** zeroes the counter and accumulators, and forces the next output cycle to `sout`=0.
  - `clr` wins over a simultaneous `sin`; that sample is discarded.
- **Output:** `dout` = 0 and `sat` = 0 whenever `sout` = 0.
- **Saturation (`sat_mode`=1):** each channel outputs min(sum, 2^DW−1).
  - `sat` = OR over channels of (sum > 2^DW−1).
  - `sat_mode` is sampled at completion.
- **Factor 1:** every `sin` produces a `sout` one cycle later with `dout` = `din`, which gives a pass-through mode.
- **Reset mid-bin:** the partial sum is lost and the next bin starts fresh.

## Timing
- Latency: `sout` is asserted exactly 1 cycle after the completing `sin` edge.
- `sout` is high for exactly 1 cycle per bin.
- Maximum throughput: one result every `bin_m` cycles with `sin` held high continuously.
- All outputs are registered; there is no combinational path from inputs to outputs.
- No back-pressure: the downstream stage must accept every `sout`.

## Structure
- Shared package `tau_pkg` holds:
  - the `clog2` function;
  - the derivation of BW and OW from DW and MAXBIN;
  - the constant `TAU_SAT_MAX(DW)` = 2^DW−1.
- The downstream RAM lag levels import the same package.
- Sub-module `tau_acc_lane`: one channel, containing
  - the OW-bit accumulator with clear and add-and-restart;
  - the saturating output mux and the per-lane clip flag.
- The top level holds the shared counter, the factor latch, `clr`/`sin` control, and a generate loop of CH lanes whose clip flags are ORed.

## Test plan
- **Basic bin:** DW=8, CH=2, `bin_m`=4, `sat_mode`=0, `sin` continuous, ch0 = 1,2,3,4 and ch1 = 255 ×4 → one `sout`, 1 cycle after the 4th sample, with ch0=10, ch1=1020, `sat`=0. Next cycle starts a new bin with no gap.
- **Saturation:** same stimulus with `sat_mode`=1 → ch0=10, ch1=255, `sat`=1. With ch1 = 10 ×4 → `sat`=0.
- **Gapped strobes:** `bin_m`=3, `sin` pulsed every 5th cycle with `din`=7 → `sout` 1 cycle after the 3rd pulse, value 21. Between strobes, `dout`=0 and the counter holds.
- **Factor edges:**
  - `bin_m`=0 → behaves as 1: each `sin` echoes `din`.
  - `bin_m`=31 → clamped to 16: sum of 16 × 255 = 4080.
  - `bin_m` changed from 4 to 2 after the 2nd sample → current bin still closes after 4 samples; the next bin closes after 2.
- **clr and reset:** `bin_m`=4, 2 samples of 5, then `clr`+`sin`(`din`=9) together, then 4 samples of 1 → `sout` with value 4; the 9 is discarded. Asserting `rst_n` low mid-bin → all outputs 0 immediately, and the next full bin sums only new samples.
- **Throughput:** `bin_m`=2, `sin` high for 10 cycles with `din` = 1…10 → 5 `sout` pulses, spaced 2 cycles apart, with values 3, 7, 11, 15, 19.
